// File: rtl/twiddle_mul_pkg.sv
// Shared constants, Q-format values and twiddle generator for the FFT datapath.
// The package is fft_pkg; every file of the twiddle stage imports it.
package fft_pkg;

  // Default datapath widths and sizes
  localparam int DEF_IN_WIDTH  = 10;
  localparam int DEF_OUT_WIDTH = 11;
  localparam int TW_WIDTH      = 9;
  localparam int DEF_NUM       = 16;
  localparam int DEF_DATA      = 512;
  localparam int DEF_BEATS     = DEF_DATA / (2 * DEF_NUM);

  // Twiddle Q1.(TW_WIDTH-2) format: +1.0, rounding bias, and rescale shift
  localparam int ONE   = 1 << (TW_WIDTH - 2);
  localparam int RND   = 1 << (TW_WIDTH - 3);
  localparam int SHIFT = TW_WIDTH - 2;

  // pi in Q30, used only for elaboration-time table generation
  localparam longint PI_Q30 = 64'sd3373259426;

  typedef struct packed {
    logic signed [TW_WIDTH-1:0] c;
    logic signed [TW_WIDTH-1:0] s;
  } twiddle_t;

  // Rounds a Q30 value times 2^(tw_width-2) to an integer, half away from zero
  function automatic longint round_q30(input longint v, input int tw_width);
    longint one_tw;
    longint half;
    one_tw = 64'sd1 << (tw_width - 2);
    half   = 64'sd1 << 29;
    if (v >= 0) return (v * one_tw + half) >>> 30;
    else        return -(((-v) * one_tw + half) >>> 30);
  endfunction

  // W^k = (round(ONE*cos), -round(ONE*sin)) of 2*pi*k/data, built with an
  // integer Taylor series so it can be evaluated at elaboration time.
  // Angles past a quarter turn are mirrored so the series stays accurate.
  function automatic twiddle_t twiddle(input int k, input int data, input int tw_width);
    longint   kk;
    longint   x;
    longint   x2;
    longint   term;
    longint   sin_q;
    longint   cos_q;
    bit       neg_cos;
    twiddle_t tw;
    kk      = longint'(k);
    neg_cos = 1'b0;
    if (2 * k > data / 2) begin
      kk      = longint'(data / 2 - k);
      neg_cos = 1'b1;
    end
    x     = (PI_Q30 * 2 * kk) / longint'(data);
    x2    = (x * x) >>> 30;
    sin_q = 0;
    term  = x;
    for (int n = 1; n <= 8; n++) begin
      sin_q = sin_q + term;
      term  = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
    end
    cos_q = 0;
    term  = 64'sd1 << 30;
    for (int n = 1; n <= 8; n++) begin
      cos_q = cos_q + term;
      term  = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
    end
    if (neg_cos) cos_q = -cos_q;
    tw.c = TW_WIDTH'(round_q30(cos_q, tw_width));
    tw.s = TW_WIDTH'(-round_q30(sin_q, tw_width));
    return tw;
  endfunction

endpackage

// File: rtl/twiddle_mul_if.sv
// Lane bus between the butterfly and the twiddle multiplier stage.
// master drives inputs into the stage, slave is the stage itself.
interface twiddle_mul_if
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int NUM       = DEF_NUM
);

  logic signed [IN_WIDTH-1:0]  din1_re  [NUM];
  logic signed [IN_WIDTH-1:0]  din1_im  [NUM];
  logic signed [IN_WIDTH-1:0]  din2_re  [NUM];
  logic signed [IN_WIDTH-1:0]  din2_im  [NUM];
  logic                        valid_in;
  logic signed [OUT_WIDTH-1:0] dout1_re [NUM];
  logic signed [OUT_WIDTH-1:0] dout1_im [NUM];
  logic signed [OUT_WIDTH-1:0] dout2_re [NUM];
  logic signed [OUT_WIDTH-1:0] dout2_im [NUM];
  logic                        valid_out;
  logic                        frame_last;

  modport master (
    output din1_re, din1_im, din2_re, din2_im, valid_in,
    input  dout1_re, dout1_im, dout2_re, dout2_im, valid_out, frame_last
  );

  modport slave (
    input  din1_re, din1_im, din2_re, din2_im, valid_in,
    output dout1_re, dout1_im, dout2_re, dout2_im, valid_out, frame_last
  );

endinterface

// File: rtl/twiddle_mul_cmul.sv
// Single-lane complex multiplier: products (stage 2), then round and narrow (stage 3).
// TWIDDLE_SAT_EN selects clamping instead of two's-complement wrap on narrowing.
module cmul
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  a,
  input  logic signed [IN_WIDTH-1:0]  b,
  input  logic signed [TW_WIDTH-1:0]  c,
  input  logic signed [TW_WIDTH-1:0]  s,
  output logic signed [OUT_WIDTH-1:0] re,
  output logic signed [OUT_WIDTH-1:0] im
);

  localparam int PW = IN_WIDTH + TW_WIDTH;
  localparam int SW = PW + 1;
  localparam int BW = SW + 1;
  localparam int RW = BW - SHIFT;

  logic signed [PW-1:0] ac;
  logic signed [PW-1:0] bs;
  logic signed [PW-1:0] as_p;
  logic signed [PW-1:0] bc;
  logic signed [BW-1:0] biased_re;
  logic signed [BW-1:0] biased_im;
  logic signed [RW-1:0] rnd_re;
  logic signed [RW-1:0] rnd_im;

  // Fits a rounded value into the output width, clamping or wrapping
  function automatic logic signed [OUT_WIDTH-1:0] narrow(input logic signed [RW-1:0] v);
`ifdef TWIDDLE_SAT_EN
    if (int'(v) > (2 ** (OUT_WIDTH - 1)) - 1) return OUT_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    if (int'(v) < -(2 ** (OUT_WIDTH - 1)))    return OUT_WIDTH'(-(2 ** (OUT_WIDTH - 1)));
    return OUT_WIDTH'(v);
`else
    return OUT_WIDTH'(v);
`endif
  endfunction

  // Stage 2: the four partial products of (a + jb)(c + js)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac   <= '0;
      bs   <= '0;
      as_p <= '0;
      bc   <= '0;
    end else begin
      ac   <= PW'(a) * PW'(c);
      bs   <= PW'(b) * PW'(s);
      as_p <= PW'(a) * PW'(s);
      bc   <= PW'(b) * PW'(c);
    end
  end

  // Combine products, add the half-LSB bias and drop the Q fraction bits
  always_comb begin
    biased_re = BW'(SW'(ac) - SW'(bs)) + BW'(RND);
    biased_im = BW'(SW'(as_p) + SW'(bc)) + BW'(RND);
    rnd_re    = $signed(biased_re[BW-1:SHIFT]);
    rnd_im    = $signed(biased_im[BW-1:SHIFT]);
  end

  // Stage 3: register the narrowed result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re <= '0;
      im <= '0;
    end else begin
      re <= narrow(rnd_re);
      im <= narrow(rnd_im);
    end
  end

endmodule

// File: rtl/twiddle_mul.sv
// Twiddle-factor stage after the radix-2 SDF butterfly: difference lanes are
// multiplied by W^k, sum lanes are sign-extended and delayed to match (3 cycles).
// Optional macro TWIDDLE_SAT_EN: saturate the multiplied path instead of wrapping.
module twiddle_mul
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int NUM       = DEF_NUM,
  parameter int DATA      = DEF_DATA
)(
  input logic         clk,
  input logic         rst,
  twiddle_mul_if.slave bus
);

  localparam int BEATS = DATA / (2 * NUM);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int KW    = $clog2(DATA / 2);

  logic [BCW-1:0]              beat;
  logic [BCW-1:0]              beat1;
  logic                        v1, v2, v3;
  logic                        l1, l2, l3;
  logic signed [IN_WIDTH-1:0]  u1_re [NUM];
  logic signed [IN_WIDTH-1:0]  u1_im [NUM];
  logic signed [IN_WIDTH-1:0]  a1_re [NUM];
  logic signed [IN_WIDTH-1:0]  a1_im [NUM];
  logic signed [OUT_WIDTH-1:0] u2_re [NUM];
  logic signed [OUT_WIDTH-1:0] u2_im [NUM];
  logic signed [OUT_WIDTH-1:0] u3_re [NUM];
  logic signed [OUT_WIDTH-1:0] u3_im [NUM];
  logic signed [OUT_WIDTH-1:0] p_re  [NUM];
  logic signed [OUT_WIDTH-1:0] p_im  [NUM];
  twiddle_t                    tw_rom [DATA/2];

  // Constant twiddle table, one entry per index k in 0..DATA/2-1
  for (genvar k = 0; k < DATA / 2; k++) begin : g_rom
    localparam twiddle_t TW_K = twiddle(k, DATA, TW_WIDTH);
    assign tw_rom[k] = TW_K;
  end

  // Beat counter: advances on valid beats only, wraps at end of frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= '0;
    end else if (bus.valid_in) begin
      beat <= (beat == BCW'(BEATS - 1)) ? '0 : beat + 1'b1;
    end
  end

  // Stage 1: capture lanes, valid, end-of-frame flag and the beat used for k
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        u1_re[i] <= '0;
        u1_im[i] <= '0;
        a1_re[i] <= '0;
        a1_im[i] <= '0;
      end
      beat1 <= '0;
      v1    <= 1'b0;
      l1    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        u1_re[i] <= bus.din1_re[i];
        u1_im[i] <= bus.din1_im[i];
        a1_re[i] <= bus.din2_re[i];
        a1_im[i] <= bus.din2_im[i];
      end
      beat1 <= beat;
      v1    <= bus.valid_in;
      l1    <= bus.valid_in && (beat == BCW'(BEATS - 1));
    end
  end

  // Stages 2-3: sum path sign-extension and delay, plus valid/last tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        u2_re[i] <= '0;
        u2_im[i] <= '0;
        u3_re[i] <= '0;
        u3_im[i] <= '0;
      end
      v2 <= 1'b0;
      v3 <= 1'b0;
      l2 <= 1'b0;
      l3 <= 1'b0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        u2_re[i] <= OUT_WIDTH'(u1_re[i]);
        u2_im[i] <= OUT_WIDTH'(u1_im[i]);
        u3_re[i] <= u2_re[i];
        u3_im[i] <= u2_im[i];
      end
      v2 <= v1;
      v3 <= v2;
      l2 <= l1;
      l3 <= l2;
    end
  end

  // One complex multiplier per lane, twiddle index k = beat*NUM + lane
  for (genvar ln = 0; ln < NUM; ln++) begin : g_lane
    logic [KW-1:0] k;
    twiddle_t      tw;
    assign k  = KW'(int'(beat1) * NUM + ln);
    assign tw = tw_rom[k];
    cmul #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_cmul (
      .clk(clk),
      .rst(rst),
      .a  (a1_re[ln]),
      .b  (a1_im[ln]),
      .c  (tw.c),
      .s  (tw.s),
      .re (p_re[ln]),
      .im (p_im[ln])
    );
  end

  assign bus.dout1_re   = u3_re;
  assign bus.dout1_im   = u3_im;
  assign bus.dout2_re   = p_re;
  assign bus.dout2_im   = p_im;
  assign bus.valid_out  = v3;
  assign bus.frame_last = l3;

endmodule

// File: tb/tb_twiddle_mul.sv
// Directed bench for twiddle_mul: a default-width instance plus a 10-bit-output
// instance sharing the same inputs (the narrow one exposes TWIDDLE_SAT_EN).
module tb_twiddle_mul;
  import fft_pkg::*;

  localparam int NUM  = DEF_NUM;
  localparam int IN_W = DEF_IN_WIDTH;

`ifdef TWIDDLE_SAT_EN
  localparam int EXP_SAT_RE = -512;
`else
  localparam int EXP_SAT_RE = 296;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   out_cnt  = 0;
  logic vq [$];

  twiddle_mul_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(DEF_OUT_WIDTH), .NUM(NUM)) bus ();
  twiddle_mul_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(10), .NUM(NUM)) bus_n ();

  twiddle_mul dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  twiddle_mul #(.OUT_WIDTH(10)) dut_n (
    .clk(clk),
    .rst(rst),
    .bus(bus_n)
  );

  assign bus_n.din1_re  = bus.din1_re;
  assign bus_n.din1_im  = bus.din1_im;
  assign bus_n.din2_re  = bus.din2_re;
  assign bus_n.din2_im  = bus.din2_im;
  assign bus_n.valid_in = bus.valid_in;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setLanes(input int d1re, input int d1im, input int d2re, input int d2im);
    for (int i = 0; i < NUM; i++) begin
      bus.din1_re[i] = IN_W'(d1re);
      bus.din1_im[i] = IN_W'(d1im);
      bus.din2_re[i] = IN_W'(d2re);
      bus.din2_im[i] = IN_W'(d2im);
    end
  endtask

  // Drive one cycle of inputs and advance to the following falling edge
  task automatic applyStimulus(input logic v, input int d2re, input int d2im,
                               input int d1re, input int d1im);
    bus.valid_in = v;
    setLanes(d1re, d1im, d2re, d2im);
    @(negedge clk);
    vq.push_back(v);
  endtask

  // Asynchronous reset pulse while the pipeline may hold data
  task automatic doReset(input string tag);
    bus.valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput({tag, "_valid_out"}, bus.valid_out, 0);
    checkOutput({tag, "_frame_last"}, bus.frame_last, 0);
    checkOutput({tag, "_dout1_re0"}, bus.dout1_re[0], 0);
    checkOutput({tag, "_dout2_re0"}, bus.dout2_re[0], 0);
    checkOutput({tag, "_dout2_im7"}, bus.dout2_im[7], 0);
    checkOutput({tag, "_n_valid_out"}, bus_n.valid_out, 0);
    @(negedge clk);
    rst = 1'b0;
    vq.delete();
    vq.push_back(1'b0);
    vq.push_back(1'b0);
  endtask

  // Per-cycle framing check: valid delayed by three, last on the 16th output
  task automatic checkFrameCycle();
    logic exp_v;
    exp_v = vq[vq.size() - 3];
    checkOutput("frm_valid_out", bus.valid_out, exp_v);
    checkOutput("frm_last", bus.frame_last, (exp_v && out_cnt == 15) ? 1 : 0);
    if (exp_v) begin
      if (out_cnt == 0 || out_cnt == 16) begin
        checkOutput("frm_k0_re", bus.dout2_re[0], 100);
        checkOutput("frm_k0_im", bus.dout2_im[0], 0);
        checkOutput("frm_k1_re", bus.dout2_re[1], 100);
        checkOutput("frm_k1_im", bus.dout2_im[1], -2);
      end else if (out_cnt == 4) begin
        checkOutput("frm_k64_re", bus.dout2_re[0], 71);
        checkOutput("frm_k64_im", bus.dout2_im[0], -71);
      end else if (out_cnt == 11) begin
        checkOutput("frm_k176_re", bus.dout2_re[0], -55);
        checkOutput("frm_k176_im", bus.dout2_im[0], -83);
      end
      out_cnt++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    setLanes(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Put live beats into the pipeline, then reset on top of them
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 55, 66, 11, 22);
    doReset("rst_mid");

    // Identity twiddle at beat 0 and sum-path passthrough
    applyStimulus(1'b1, 100, -37, -512, 511);
    applyStimulus(1'b0, 0, 0, 0, 0);
    checkOutput("lat_not_early", bus.valid_out, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    checkOutput("id_valid_out", bus.valid_out, 1);
    checkOutput("id_re_l0", bus.dout2_re[0], 100);
    checkOutput("id_im_l0", bus.dout2_im[0], -37);
    checkOutput("id_re_l1", bus.dout2_re[1], 99);
    checkOutput("id_im_l1", bus.dout2_im[1], -39);
    checkOutput("up_re_l0", bus.dout1_re[0], -512);
    checkOutput("up_im_l0", bus.dout1_im[0], 511);
    checkOutput("up_re_l15", bus.dout1_re[15], -512);
    checkOutput("up_n_re_l0", bus_n.dout1_re[0], -512);
    checkOutput("up_n_im_l0", bus_n.dout1_im[0], 511);

    // Quarter turn: beat 8, lane 0
    for (int i = 1; i < 8; i++) applyStimulus(1'b1, 0, 0, 0, 0);
    applyStimulus(1'b1, 200, 50, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    checkOutput("qt_re", bus.dout2_re[0], 50);
    checkOutput("qt_im", bus.dout2_im[0], -200);

    // 45 degrees: beat 4, lane 0, counter restarted by reset
    doReset("rst_45");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 0, 0, 0);
    applyStimulus(1'b1, 100, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    checkOutput("d45_re", bus.dout2_re[0], 71);
    checkOutput("d45_im", bus.dout2_im[0], -71);

    // Overflow on the 10-bit instance, in range on the 11-bit one
    doReset("rst_sat");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 0, 0, 0);
    applyStimulus(1'b1, -512, -512, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0);
    checkOutput("sat_n_re", bus_n.dout2_re[0], EXP_SAT_RE);
    checkOutput("sat_n_im", bus_n.dout2_im[0], 0);
    checkOutput("sat_wide_re", bus.dout2_re[0], -728);
    checkOutput("sat_wide_im", bus.dout2_im[0], 0);

    // Full frame with gaps after beats 3 and 10, then next frame beat 0
    doReset("rst_frm");
    out_cnt = 0;
    for (int b = 0; b < 16; b++) begin
      applyStimulus(1'b1, 100, 0, 0, 0);
      checkFrameCycle();
      if (b == 3 || b == 10) begin
        for (int g = 0; g < 2; g++) begin
          applyStimulus(1'b0, 0, 0, 0, 0);
          checkFrameCycle();
        end
      end
    end
    applyStimulus(1'b1, 100, 0, 0, 0);
    checkFrameCycle();
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b0, 0, 0, 0, 0);
      checkFrameCycle();
    end
    checkOutput("frm_out_count", out_cnt, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/twiddle_mul.md
# twiddle_mul

Twiddle-factor multiplier stage placed directly downstream of `butterfly` in the radix-2 SDF FFT datapath. It consumes the NUM-lane sum (`do1_*`) and difference (`do2_*`) outputs of the butterfly. It multiplies each difference lane by its twiddle factor W^k = exp(-j2πk/DATA) and passes the sum lanes through delay-matched. The result is a 3-stage pipelined, rounded and optionally saturated output for the next stage.

## Interface
- `IN_WIDTH`, 10, signed input bit width (butterfly OUT_WIDTH)
- `OUT_WIDTH`, 11, signed output bit width
- `TW_WIDTH`, 9, signed twiddle width, Q1.(TW_WIDTH-2); +1.0 = 2^(TW_WIDTH-2) = 128
- `NUM`, 16, number of parallel lanes
- `DATA`, 512, FFT size
- `BEATS`, DATA/(2*NUM) = 16, valid beats per frame
- `clk`  input  1  clock, all state on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `din1_re`, `din1_im`  input  signed [IN_WIDTH-1:0] [0:NUM-1]  sum path (upper)
- `din2_re`, `din2_im`  input  signed [IN_WIDTH-1:0] [0:NUM-1]  difference path (lower)
- `valid_in`  input  1  lanes valid this cycle
- `dout1_re`, `dout1_im`  output  signed [OUT_WIDTH-1:0] [0:NUM-1]  delayed sum path, sign-extended
- `dout2_re`, `dout2_im`  output  signed [OUT_WIDTH-1:0] [0:NUM-1]  din2·W^k
- `valid_out`  output  1  outputs valid
- `frame_last`  output  1  high with valid_out on the last beat of a frame

## Operation
- Beat counter `beat` (0..BEATS-1) advances only on `valid_in`. It wraps from BEATS-1 to 0. A gap in `valid_in` holds it.
- Twiddle index per lane is k = beat·NUM + lane, range 0..DATA/2-1.
- W^k = (c, s) with c = round(128·cos(2πk/DATA)) and s = -round(128·sin(2πk/DATA)). Round half away from zero.
- Twiddles come from a constant table of DATA/2 entries, read combinationally per lane.
- Product for the lower path, with a = din2_re, b = din2_im:
  - re = a·c - b·s
  - im = a·s + b·c
  - Products are IN_WIDTH+TW_WIDTH bits; the sum is one bit wider.
- Scaling: add 2^(TW_WIDTH-3) (= 64), then arithmetic shift right by TW_WIDTH-2 (= 7). This is round half up.
- Narrowing to OUT_WIDTH is governed by `TWIDDLE_SAT_EN` (see Configuration).
- Upper path: sign-extended to OUT_WIDTH and delayed to match. It is never saturated or rounded.
- The pipeline advances every cycle, with no stall. Valid bits shift alongside the data. Bubbles propagate as `valid_out` = 0. Data regs may update on invalid beats.
- `frame_last` is asserted when the beat that entered with `beat` = BEATS-1 exits.

## Timing
- Stage 1: register inputs, `valid_in`, and k.
- Stage 2: register the four lane products and the sign-extended upper path.
- Stage 3: register the rounded, narrowed outputs.
- Latency: `valid_in` at cycle t produces `valid_out` at t+3. Throughput is one beat per cycle.
- Reset: all outputs, `valid_out`, `frame_last`, `beat`, and pipeline valids go to 0 immediately. Data regs go to 0.
- Reset mid-frame: in-flight beats are discarded. The first `valid_in` after deassertion uses k = lane (beat 0).
- Back-to-back frames: beat BEATS-1 is followed immediately by beat 0 of the next frame, with no idle cycle.

## Configuration
- `TWIDDLE_SAT_EN` defined: the lower-path result clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Not defined: the lower-path result is truncated to the low OUT_WIDTH bits (two's-complement wrap).
- At default widths overflow cannot occur, so both builds are identical. The difference is observable only with a narrower OUT_WIDTH.

## Structure
- Package `fft_pkg` holds:
  - the width and size constants;
  - the Q-format localparams (ONE = 128, RND = 64, SHIFT = 7);
  - a constant function returning the (c, s) twiddle for index k, given DATA and TW_WIDTH.
- Sub-module `cmul` is a single-lane complex multiplier covering stages 2–3, including round and narrowing. It is instantiated NUM times by generate.

## Test plan
- Reset and identity: assert `rst` mid-stream; all outputs and `valid_out` read 0. Then send beat 0 with din2 = (100, -37) on all lanes. Lane 0 (k = 0, W = (128, 0)) gives dout2 = (100, -37) at t+3.
- Quarter turn: beat 8, lane 0 (k = 128, W = (0, -128)) with din2 = (200, 50) -> dout2 = (50, -200).
- 45°: beat 4, lane 0 (k = 64, W = (91, -91)) with din2 = (100, 0) -> dout2 = (71, -71).
- Saturation, with OUT_WIDTH = 10: k = 64, din2 = (-512, -512) -> re = -728 before narrowing.
  - With `TWIDDLE_SAT_EN`: dout2_re = -512.
  - Without it: dout2_re = 296 (wrap).
  - dout2_im = 0 in both builds.
- Gaps and framing: 16 valid beats with 2-cycle gaps after beats 3 and 10.
  - `beat` holds during the gaps.
  - `valid_out` mirrors the input pattern delayed 3 cycles.
  - `frame_last` pulses once, on the 16th output.
  - An immediate next frame restarts at k = lane.
- Upper path: din1 = (-512, 511) -> dout1 = (-512, 511) at t+3, with no rounding in either build.
